multi_counter: RTL

Parametrised bank of N independent modulo counters, each with enable, direction, synchronous load, and wrap-or-saturate terminal behaviour. It supersedes the single free-running up-counter used as a model-checking example. It gives the formal flow a scalable design: width, channel count, limit and mode widen the state space without changing the property set. Embedded safety and liveness properties are compiled in by define.

---
 rtl/multi_counter.sv | 109 ++++++++++
 1 files changed

// File: rtl/multi_counter.sv
// multi_counter
//   Bank of N independent modulo counters. Each channel has its own enable,
//   direction and synchronous load, and either wraps or saturates at the
//   ends of its 0..LIMIT range (SAT selects the behaviour for all channels).
//
// Parameters
//   W      counter width per channel (1..32)
//   N      number of channels (1..16)
//   LIMIT  terminal value, 1 <= LIMIT <= 2**W-1
//   SAT    0 = wrap at the ends, 1 = saturate at the ends
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-low reset
//   en        [N]    per-channel count enable
//   up        [N]    per-channel direction (1 = up, 0 = down)
//   load      [N]    per-channel synchronous load request (beats en)
//   load_val  [N*W]  load values, channel i at [i*W +: W]; clamped to LIMIT
//   count     [N*W]  registered counter values, packed like load_val
//   tc        [N]    combinational terminal flag: count == LIMIT going up,
//                    count == 0 going down
//   wrap      [N]    registered one-cycle pulse, high in the cycle that
//                    first shows a wrapped value
//
// Optional formal properties are compiled in by defining S0, S1, L0 or L1.

module multi_counter #(
  parameter int          W     = 10,
  parameter int          N     = 2,
  parameter logic [31:0] LIMIT = 32'((64'd1 << W) - 64'd1),
  parameter bit          SAT   = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   en,
  input  logic [N-1:0]   up,
  input  logic [N-1:0]   load,
  input  logic [N*W-1:0] load_val,
  output logic [N*W-1:0] count,
  output logic [N-1:0]   tc,
  output logic [N-1:0]   wrap
);

  // All comparisons happen at the counter width; there is no carry out.
  localparam logic [W-1:0] LIM = LIMIT[W-1:0];

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [W-1:0] lv;
    // Declaration initialisers put formal runs in the reset state from
    // the first cycle; the reset branch below is still the real reset.
    logic [W-1:0] cnt_q  = '0;
    logic         wrap_q = 1'b0;

    assign lv = load_val[i*W +: W];

    // NOTE: state registers use non-blocking assignments so every channel
    // samples the pre-edge value of its own state regardless of process order.
    always_ff @(posedge clk) begin
      wrap_q <= 1'b0;
      if (!rst) begin
        cnt_q <= '0;
      end else if (load[i]) begin
        cnt_q <= (lv > LIM) ? LIM : lv;
      end else if (en[i]) begin
        if (up[i]) begin
          if (cnt_q != LIM) begin
            cnt_q <= cnt_q + W'(1);
          end else if (!SAT) begin
            cnt_q  <= '0;
            wrap_q <= 1'b1;
          end
        end else begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
          end else if (!SAT) begin
            cnt_q  <= LIM;
            wrap_q <= 1'b1;
          end
        end
      end
    end

    assign count[i*W +: W] = cnt_q;
    assign wrap[i]         = wrap_q;
    assign tc[i]           = up[i] ? (cnt_q == LIM) : (cnt_q == '0);

`ifdef S0
    a_s0_range : assert property (@(posedge clk) cnt_q <= LIM);
`endif
`ifdef S1
    a_s1_wrap_val : assert property (@(posedge clk)
      wrap_q |-> (cnt_q == '0 || cnt_q == LIM));
    a_s1_no_wrap_sat : assert property (@(posedge clk) SAT |-> !wrap_q);
`endif
  end

`ifdef L0
  // Expected to fail: nothing forces en[0] high.
  a_l0_reach : assert property (@(posedge clk)
    s_eventually (count[W-1:0] == LIM));
`endif
`ifdef L1
  m_l1_drive : assume property (@(posedge clk)
    rst && en[0] && up[0] && !load[0]);
  a_l1_reach : assert property (@(posedge clk)
    s_eventually (count[W-1:0] == LIM));
`endif

endmodule
